uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-mode constants, majority vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } rx_state_e;

  // Parity selections are 4-character strings packed into 32 bits
  localparam logic [31:0] PAR_NONE = "NONE";
  localparam logic [31:0] PAR_ODD  = {8'h00, "ODD"};
  localparam logic [31:0] PAR_EVEN = "EVEN";

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; read data is combinational from the head slot.
module sync_fifo #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned ASIZE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_rd,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_empty,
  output logic              o_full
);
  localparam int unsigned DEPTH = 2 ** ASIZE;

  logic [ASIZE:0]    r_wptr, r_rptr;
  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic              w_wr, w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[ASIZE] != r_rptr[ASIZE]) &&
                   (r_wptr[ASIZE-1:0] == r_rptr[ASIZE-1:0]);
  assign w_rd    = i_rd && !o_empty;
  // A read in the same cycle frees the slot, so a full FIFO still accepts
  assign w_wr    = i_wr && (!o_full || w_rd);
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[ASIZE-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[ASIZE-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver: 2-flop sync, 3-sample majority per bit, optional parity, output FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 868,
  parameter logic [31:0] PARITY     = PAR_NONE,
  parameter int unsigned FIFO_ASIZE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_en,
  input  logic       rx_rdy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);
  localparam int            CW         = $clog2(CLK_DIV);
  localparam logic [CW-1:0] SMP_0      = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] SMP_1      = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] SMP_DEC    = CW'(CLK_DIV / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam bit            PAR_EN     = (PARITY != PAR_NONE);
  localparam bit            PAR_IS_ODD = (PARITY == PAR_ODD);

  logic [1:0]    r_sync, r_warm, r_smp;
  logic          r_rx_d;
  rx_state_e     r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_par_ok, r_perr, r_ferr, r_ovf;
  logic          w_rx, w_maj, w_dec, w_wrap, w_rd, w_empty, w_full;
  logic          w_push, w_perr, w_ferr, w_ovf;
  logic [7:0]    w_fdata;

  assign w_rx       = r_sync[1];
  assign w_maj      = maj3(r_smp[1], r_smp[0], w_rx);
  assign w_dec      = (r_cnt == SMP_DEC);
  assign w_wrap     = (r_cnt == CNT_LAST);
  assign w_rd       = rx_en & rx_rdy;
  assign rx_en      = ~w_empty;
  assign rx_data    = w_fdata;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overflow   = r_ovf;

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    w_perr = 1'b0;
    w_ferr = 1'b0;
    w_ovf  = 1'b0;
    unique case (r_state)
      ST_IDLE:   if (r_rx_d && !w_rx) w_next = ST_START;
      ST_START:  if (w_dec && w_maj) w_next = ST_IDLE;
                 else if (w_wrap)    w_next = ST_DATA;
      ST_DATA:   if (w_wrap && r_bit == 3'd7) w_next = PAR_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_wrap) w_next = ST_STOP;
      // Leave mid stop bit so an early next start edge is still caught
      ST_STOP: if (w_dec) begin
        if (!w_maj) begin
          w_ferr = 1'b1;
          w_next = ST_BREAK;
        end else begin
          w_next = ST_IDLE;
          if (!r_par_ok)            w_perr = 1'b1;
          else if (w_full && !w_rd) w_ovf  = 1'b1;
          else                      w_push = 1'b1;
        end
      end
      ST_BREAK: if (w_rx) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= 2'b11;
      r_warm   <= '0;
      r_rx_d   <= 1'b0;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_smp    <= '0;
      r_par_ok <= 1'b1;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_uart_rx};
      r_warm  <= {r_warm[0], 1'b1};
      // Ignore the reset-value ones still in the synchronizer: a line held low
      // through reset must not look like a fresh falling edge
      r_rx_d  <= r_warm[1] & w_rx;
      r_state <= w_next;
      if (r_state == ST_IDLE || r_state == ST_BREAK || w_wrap) r_cnt <= '0;
      else                                                     r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_START) begin
        r_bit    <= '0;
        r_par_ok <= 1'b1;
      end else if (r_state == ST_DATA && w_wrap) begin
        r_bit <= r_bit + 1'b1;
      end
      if (r_cnt == SMP_0 || r_cnt == SMP_1) r_smp <= {r_smp[0], w_rx};
      if (r_state == ST_DATA && w_dec)      r_shift <= {w_maj, r_shift[7:1]};
      if (r_state == ST_PARITY && w_dec)    r_par_ok <= (((^r_shift) ^ w_maj) == PAR_IS_ODD);
      r_perr <= w_perr;
      r_ferr <= w_ferr;
      r_ovf  <= w_ovf;
    end
  end

  sync_fifo #(.DWIDTH(8), .ASIZE(FIFO_ASIZE)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_wr   (w_push),
    .i_wdata(r_shift),
    .i_rd   (w_rd),
    .o_rdata(w_fdata),
    .o_empty(w_empty),
    .o_full (w_full)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: four instances (plain, even parity, shallow FIFO, 868 divider).
module tb_uart_rx;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] ln, rdy, en, perr, ferr, ovf;
  logic [7:0] rxd [4];

  uart_rx #(.CLK_DIV(16)) u_a (
    .clk(clk), .rst(rst), .i_uart_rx(ln[0]), .rx_data(rxd[0]), .rx_en(en[0]), .rx_rdy(rdy[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .overflow(ovf[0]));
  uart_rx #(.CLK_DIV(16), .PARITY(PAR_EVEN)) u_b (
    .clk(clk), .rst(rst), .i_uart_rx(ln[1]), .rx_data(rxd[1]), .rx_en(en[1]), .rx_rdy(rdy[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .overflow(ovf[1]));
  uart_rx #(.CLK_DIV(16), .FIFO_ASIZE(2)) u_c (
    .clk(clk), .rst(rst), .i_uart_rx(ln[2]), .rx_data(rxd[2]), .rx_en(en[2]), .rx_rdy(rdy[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]), .overflow(ovf[2]));
  uart_rx #(.CLK_DIV(868)) u_d (
    .clk(clk), .rst(rst), .i_uart_rx(ln[3]), .rx_data(rxd[3]), .rx_en(en[3]), .rx_rdy(rdy[3]),
    .parity_err(perr[3]), .frame_err(ferr[3]), .overflow(ovf[3]));

  // Transfer and pulse counters, sampled on the edge where the transfer happens
  int         en_cnt [4];
  int         perr_cnt [4];
  int         ferr_cnt [4];
  int         ovf_cnt [4];
  logic [7:0] last_d [4];
  logic [7:0] qc[$], qd[$];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (en[i] === 1'b1 && rdy[i] === 1'b1) begin
        en_cnt[i]++;
        last_d[i] = rxd[i];
        if (i == 2) qc.push_back(rxd[i]);
        if (i == 3) qd.push_back(rxd[i]);
      end
      if (perr[i] === 1'b1) perr_cnt[i]++;
      if (ferr[i] === 1'b1) ferr_cnt[i]++;
      if (ovf[i] === 1'b1)  ovf_cnt[i]++;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input int idx, input logic v, input int n);
    ln[idx] = v;
    repeat (n) @(negedge clk);
  endtask

  // par: 0 none, 1 correct even parity, 2 inverted even parity
  task automatic send_frame(input int idx, input logic [7:0] d, input int par, input int bitlen);
    logic p;
    p = ^d;
    if (par == 2) p = ~p;
    put(idx, 1'b0, bitlen);
    for (int b = 0; b < 8; b++) put(idx, d[b], bitlen);
    if (par != 0) put(idx, p, bitlen);
    put(idx, 1'b1, bitlen);
  endtask

  typedef struct {
    int         idx;
    logic [7:0] d;
    int         par;
    int         exp_en;
    int         exp_perr;
  } vec_t;

  vec_t vt [9];
  int   e0, p0, f0, o0;

  initial begin
    vt[0] = '{0, 8'h55, 0, 1, 0};
    vt[1] = '{0, 8'h00, 0, 1, 0};
    vt[2] = '{0, 8'hFF, 0, 1, 0};
    vt[3] = '{0, 8'hA5, 0, 1, 0};
    vt[4] = '{1, 8'hA7, 2, 0, 1};
    vt[5] = '{1, 8'h3C, 1, 1, 0};
    vt[6] = '{1, 8'h00, 1, 1, 0};
    vt[7] = '{1, 8'hFF, 1, 1, 0};
    vt[8] = '{1, 8'h01, 1, 1, 0};

    rst = 1'b1;
    ln  = 4'hF;
    rdy = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset rx_en", en[0], 0);
    chk("reset rx_data", rxd[0], 0);
    chk("reset err pulses", {perr[0], ferr[0], ovf[0]}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Exact delivery latency: stop decision 154 cycles after the synced edge
    e0 = en_cnt[0];
    fork
      send_frame(0, 8'h55, 0, 16);
      begin
        repeat (156) @(negedge clk);
        chk("latency before", en[0], 0);
        @(negedge clk);
        chk("latency rx_en", en[0], 1);
        chk("latency data", rxd[0], 8'h55);
        @(negedge clk);
        chk("single pulse", en[0], 0);
      end
    join
    repeat (16) @(negedge clk);
    chk("0x55 count", en_cnt[0] - e0, 1);

    // Table vectors
    for (int v = 0; v < 9; v++) begin
      e0 = en_cnt[vt[v].idx];
      p0 = perr_cnt[vt[v].idx];
      f0 = ferr_cnt[vt[v].idx];
      send_frame(vt[v].idx, vt[v].d, vt[v].par, 16);
      repeat (32) @(negedge clk);
      chk($sformatf("vec%0d rx_en count", v), en_cnt[vt[v].idx] - e0, vt[v].exp_en);
      if (vt[v].exp_en != 0) chk($sformatf("vec%0d data", v), last_d[vt[v].idx], vt[v].d);
      chk($sformatf("vec%0d parity_err", v), perr_cnt[vt[v].idx] - p0, vt[v].exp_perr);
      chk($sformatf("vec%0d frame_err", v), ferr_cnt[vt[v].idx] - f0, 0);
    end

    // Break: line low 20 bit times after the start bit
    e0 = en_cnt[0]; p0 = perr_cnt[0]; f0 = ferr_cnt[0];
    put(0, 1'b0, 21 * 16);
    put(0, 1'b1, 48);
    chk("break frame_err", ferr_cnt[0] - f0, 1);
    chk("break no byte", en_cnt[0] - e0, 0);
    send_frame(0, 8'h81, 0, 16);
    repeat (32) @(negedge clk);
    chk("after break count", en_cnt[0] - e0, 1);
    chk("after break data", last_d[0], 8'h81);
    chk("after break errs", (ferr_cnt[0] - f0) + (perr_cnt[0] - p0), 1);

    // 3-cycle glitch is rejected silently
    e0 = en_cnt[0]; f0 = ferr_cnt[0];
    put(0, 1'b0, 3);
    put(0, 1'b1, 40);
    chk("glitch no byte", en_cnt[0] - e0, 0);
    chk("glitch no err", ferr_cnt[0] - f0, 0);
    send_frame(0, 8'h3C, 0, 16);
    repeat (32) @(negedge clk);
    chk("post glitch data", last_d[0], 8'h3C);

    // Overflow on a 4-deep FIFO
    rdy[2] = 1'b0;
    o0 = ovf_cnt[2];
    for (int b = 1; b <= 4; b++) send_frame(2, 8'(b), 0, 16);
    chk("fifo 4 no ovf", ovf_cnt[2] - o0, 0);
    chk("fifo head held", rxd[2], 8'h01);
    send_frame(2, 8'h05, 0, 16);
    repeat (32) @(negedge clk);
    chk("fifo overflow", ovf_cnt[2] - o0, 1);
    rdy[2] = 1'b1;
    repeat (10) @(negedge clk);
    chk("fifo drain count", qc.size(), 4);
    for (int j = 0; j < 4; j++)
      chk($sformatf("fifo order %0d", j), (j < qc.size()) ? 32'(qc[j]) : 32'hFFFF_FFFF, j + 1);
    chk("fifo empty", en[2], 0);

    // +2% transmitter against an 868 divider, back to back
    e0 = en_cnt[3];
    send_frame(3, 8'h00, 0, 851);
    send_frame(3, 8'hFF, 0, 851);
    repeat (1000) @(negedge clk);
    chk("fast tx count", en_cnt[3] - e0, 2);
    chk("fast tx byte0", (qd.size() > 0) ? 32'(qd[0]) : 32'hFFFF_FFFF, 8'h00);
    chk("fast tx byte1", (qd.size() > 1) ? 32'(qd[1]) : 32'hFFFF_FFFF, 8'hFF);
    chk("fast tx errs", perr_cnt[3] + ferr_cnt[3], 0);

    // Reset mid-frame flushes the FIFO; a line held low afterwards starts nothing
    rdy[0] = 1'b0;
    e0 = en_cnt[0]; p0 = perr_cnt[0]; f0 = ferr_cnt[0];
    send_frame(0, 8'h11, 0, 16);
    repeat (8) @(negedge clk);
    chk("hold rx_en", en[0], 1);
    chk("hold rx_data", rxd[0], 8'h11);
    put(0, 1'b0, 16 + 4 * 16 + 8);
    rst = 1'b1;
    put(0, 1'b0, 2);
    rst = 1'b0;
    put(0, 1'b0, 48);
    put(0, 1'b1, 40);
    chk("rst flushed", en[0], 0);
    chk("rst errs", (perr_cnt[0] - p0) + (ferr_cnt[0] - f0), 0);
    rdy[0] = 1'b1;
    send_frame(0, 8'h5A, 0, 16);
    repeat (32) @(negedge clk);
    chk("post rst count", en_cnt[0] - e0, 1);
    chk("post rst data", last_d[0], 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
